cache_arbiter: RTL and testbench

//  Shares the single physical-memory (L2/pmem) line port between the I-cache miss path (port A) and
//  the D-cache miss path (port B) of the LC-3b pipeline. Serialises line fills and writebacks.

---
 rtl/cache_arbiter_pkg.sv | 10 +
 rtl/cache_arbiter.sv | 97 +++++++++
 tb/tb_cache_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared line/word types and arbiter state encoding
// Provides lc3b_c_line (128-bit cache line), lc3b_word (16-bit address)
// and lc3b_arb_state (the arbiter FSM states).
package cache_arbiter_pkg;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [1:0] {arb_idle, arb_grant_i, arb_grant_d, arb_done} lc3b_arb_state;
  localparam int ARB_LINE_WIDTH = 128;
  localparam int ARB_MAX_D_STREAK = 4;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the pmem line port between I-cache (A) and D-cache (B) miss paths
// Ports:
//   clk, reset (async, active-high)
//   icache_read/addr in, icache_rdata/resp out      : I-cache line fills
//   dcache_read/write/addr/wdata in, rdata/resp out : D-cache fills and writebacks
//   pmem_read/write/addr/wdata out, pmem_rdata/resp in : physical memory line port
// D requests win unless an I fill has waited through MAX_D_STREAK consecutive D grants.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH = ARB_LINE_WIDTH,
  parameter int MAX_D_STREAK = ARB_MAX_D_STREAK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_read,
  input  lc3b_word              icache_addr,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  lc3b_word              dcache_addr,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output lc3b_word              pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  lc3b_arb_state state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  lc3b_word addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic write_q, write_d;
  logic d_req, d_wins;
  assign d_req = dcache_read | dcache_write;
  // I only overtakes a pending D request once the D streak has saturated.
  assign d_wins = d_req & (~icache_read | (streak_q < STREAK_MAX));
  always_comb begin
    state_d = state_q;
    streak_d = streak_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    unique case (state_q)
      arb_idle:
        if (d_wins) begin
          state_d = arb_grant_d;
          addr_d = dcache_addr;
          wdata_d = dcache_wdata;
          write_d = dcache_write;
          streak_d = !icache_read ? '0 : (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
        end else if (icache_read) begin
          state_d = arb_grant_i;
          addr_d = icache_addr;
          streak_d = '0;
        end
      arb_grant_i, arb_grant_d: state_d = pmem_resp ? arb_done : state_q;
      arb_done: state_d = arb_idle;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= arb_idle;
      streak_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      streak_q <= streak_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end
  assign pmem_read = (state_q == arb_grant_i) | ((state_q == arb_grant_d) & ~write_q);
  assign pmem_write = (state_q == arb_grant_d) & write_q;
  assign pmem_addr = addr_q;
  assign pmem_wdata = wdata_q;
  assign icache_resp = pmem_resp & (state_q == arb_grant_i);
  assign dcache_resp = pmem_resp & (state_q == arb_grant_d);
  assign icache_rdata = icache_resp ? pmem_rdata : '0;
  assign dcache_rdata = dcache_resp ? pmem_rdata : '0;
`ifndef SYNTHESIS
  a_resp_onehot: assert property (@(posedge clk) disable iff (reset) !(icache_resp && dcache_resp));
  a_no_rw_strobe: assert property (@(posedge clk) disable iff (reset) !(pmem_read && pmem_write));
  a_strobe_stable: assert property (@(posedge clk) disable iff (reset)
    ((state_q inside {arb_grant_i, arb_grant_d}) && ($past(state_q) == state_q)) |-> $stable({pmem_read, pmem_write}));
  a_d_req_legal: assert property (@(posedge clk) disable iff (reset) !(dcache_read && dcache_write));
`endif
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: table-driven cycle trace plus starvation and reset sequences
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;
  localparam logic [127:0] RDATA = {16{8'hA5}};
  localparam logic [127:0] WDATA = {16{8'h0F}};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic icache_read = 1'b0, dcache_read = 1'b0, dcache_write = 1'b0, pmem_resp = 1'b0;
  logic [15:0] icache_addr = 16'h1230, dcache_addr = 16'h4000, pmem_addr;
  logic [127:0] icache_rdata, dcache_rdata, pmem_wdata;
  logic [127:0] dcache_wdata = WDATA, pmem_rdata = RDATA;
  logic icache_resp, dcache_resp, pmem_read, pmem_write;
  int checks = 0, errors = 0;
  typedef struct {
    logic ir, dr, dw, pr;
    logic [3:0] exp_o;
    logic [15:0] exp_addr;
  } vec_t;
  vec_t vq[$];
  cache_arbiter dut (
    .clk(clk), .reset(reset),
    .icache_read(icache_read), .icache_addr(icache_addr), .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic ir, dr, dw, pr, input logic [3:0] o, input logic [15:0] a);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.pr = pr; v.exp_o = o; v.exp_addr = a;
    vq.push_back(v);
  endtask
  function automatic logic [3:0] outs();
    return {pmem_read, pmem_write, icache_resp, dcache_resp};
  endfunction
  // Waits for a grant strobe, answers it one cycle later, then drops the served requester in DONE.
  task automatic serve(input string tag, output logic got_d);
    int n = 0;
    got_d = 1'b0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(pmem_read || pmem_write) && n < 10);
    if (!(pmem_read || pmem_write)) begin
      checks++;
      errors++;
      $display("FAIL %s: no strobe within 10 cycles", tag);
      return;
    end
    got_d = (pmem_addr == 16'h4000);
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk({tag, "_resp"}, 128'({icache_resp, dcache_resp}), got_d ? 128'd1 : 128'd2);
    @(negedge clk);
    pmem_resp = 1'b0;
    if (got_d) begin
      dcache_read = 1'b0;
      dcache_write = 1'b0;
    end else icache_read = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic g;
    logic exp_d[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int n;
    // I-only fill with 5-cycle memory, stray resp in IDLE
    add(1,0,0,0, 4'b0000, 16'h0000);
    for (int i = 0; i < 4; i++) add(1,0,0,0, 4'b1000, 16'h1230);
    add(1,0,0,1, 4'b1010, 16'h1230);
    add(0,0,0,0, 4'b0000, 16'h1230);
    add(0,0,0,1, 4'b0000, 16'h1230);
    // D writeback
    add(0,0,1,0, 4'b0000, 16'h1230);
    add(0,0,1,0, 4'b0100, 16'h4000);
    add(0,0,1,0, 4'b0100, 16'h4000);
    add(0,0,1,1, 4'b0101, 16'h4000);
    add(0,0,0,0, 4'b0000, 16'h4000);
    // simultaneous I and D read: D first, then I
    add(1,1,0,0, 4'b0000, 16'h4000);
    add(1,1,0,0, 4'b1000, 16'h4000);
    add(1,1,0,1, 4'b1001, 16'h4000);
    add(1,0,0,0, 4'b0000, 16'h4000);
    add(1,0,0,0, 4'b0000, 16'h4000);
    // I served, then held through resp: one-cycle DONE gap, regrant
    add(1,0,0,1, 4'b1010, 16'h1230);
    add(1,0,0,0, 4'b0000, 16'h1230);
    add(1,0,0,0, 4'b0000, 16'h1230);
    add(1,0,0,1, 4'b1010, 16'h1230);
    add(0,0,0,1, 4'b0000, 16'h1230);
    add(0,0,0,0, 4'b0000, 16'h1230);
    #1;
    chk("reset_outs", 128'(outs()), 128'd0);
    chk("reset_state", 128'(dut.state_q), 128'(arb_idle));
    chk("reset_addr", 128'(pmem_addr), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    foreach (vq[i]) begin
      if (i > 0) @(negedge clk);
      icache_read = vq[i].ir;
      dcache_read = vq[i].dr;
      dcache_write = vq[i].dw;
      pmem_resp = vq[i].pr;
      #1;
      chk($sformatf("vec%0d_outs", i), 128'(outs()), 128'(vq[i].exp_o));
      chk($sformatf("vec%0d_addr", i), 128'(pmem_addr), 128'(vq[i].exp_addr));
      if (vq[i].exp_o[1]) chk($sformatf("vec%0d_irdata", i), icache_rdata, RDATA);
      if (vq[i].exp_o[0]) chk($sformatf("vec%0d_drdata", i), dcache_rdata, RDATA);
      if (vq[i].exp_o[2]) chk($sformatf("vec%0d_wdata", i), pmem_wdata, WDATA);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    icache_read = 1'b0;
    // starvation: expect D,D,D,D,I,D
    icache_read = 1'b1;
    dcache_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve($sformatf("starve%0d", k), g);
      chk($sformatf("starve%0d_grant_d", k), 128'(g), 128'(exp_d[k]));
      if (k == 3) chk("streak_sat", 128'(dut.streak_q), 128'd4);
      if (k == 4) chk("streak_after_i", 128'(dut.streak_q), 128'd0);
      if (g) begin
        @(negedge clk);
        if (k < 5) dcache_read = 1'b1;
      end
    end
    // reset mid GRANT_D writeback, then re-issued request
    @(negedge clk);
    icache_read = 1'b0;
    dcache_read = 1'b0;
    dcache_write = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!pmem_write && n < 10);
    chk("rst_pre_write", 128'(pmem_write), 128'd1);
    chk("rst_pre_wdata", pmem_wdata, WDATA);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", 128'(outs()), 128'd0);
    chk("rst_mid_state", 128'(dut.state_q), 128'(arb_idle));
    chk("rst_mid_wdata", pmem_wdata, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    serve("reissue", g);
    chk("reissue_grant_d", 128'(g), 128'd1);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
